// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory between a pipeline port (A)
// and a loader/debug port (B), with short locked bursts. Optional: DMEM_ARB_BOUNDS_CHK_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 4,
  parameter int unsigned DEPTH    = 256
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic              a_lock_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_gnt_o,
  output logic              a_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic              b_lock_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_gnt_o,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              MemWrite_o,
  output logic              MemRead_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] WriteData_o,
  input  logic [DATA_W-1:0] ReadData_i
`ifdef DMEM_ARB_BOUNDS_CHK_EN
  ,
  output logic              err_o
`endif
);

  localparam int unsigned CNT_W   = 4;
  localparam bit          LOCK_EN = (MAX_LOCK > 1);

  if (MAX_LOCK == 0 || MAX_LOCK > 15 || DEPTH == 0) begin : g_param_chk
    $error("dmem_arbiter: MAX_LOCK must be 1..15 and DEPTH must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  // r_rr_last: 0 = A granted last, 1 = B granted last
  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_rr_last;
  logic               w_rr_last_nxt;
  logic [CNT_W-1:0]   r_lock_cnt;
  logic [CNT_W-1:0]   w_lock_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_gnt_a;
  logic               w_gnt_b;
  logic               w_gnt_any;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_oob;
  logic               r_rvalid_a;
  logic               r_rvalid_b;
  logic               r_rd_oob;

  assign w_cnt_inc = r_lock_cnt + CNT_W'(1);

  // Grant selection and lock tracking; grants are suppressed while reset is held
  always_comb begin
    w_gnt_a        = 1'b0;
    w_gnt_b        = 1'b0;
    w_state_nxt    = r_state;
    w_rr_last_nxt  = r_rr_last;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      ST_IDLE: begin
        if (a_req_i && (!b_req_i || r_rr_last)) begin
          w_gnt_a       = rst_n_i;
          w_rr_last_nxt = 1'b0;
          if (a_lock_i && LOCK_EN) begin
            w_state_nxt    = ST_LOCK_A;
            w_lock_cnt_nxt = CNT_W'(1);
          end
        end else if (b_req_i) begin
          w_gnt_b       = rst_n_i;
          w_rr_last_nxt = 1'b1;
          if (b_lock_i && LOCK_EN) begin
            w_state_nxt    = ST_LOCK_B;
            w_lock_cnt_nxt = CNT_W'(1);
          end
        end
      end
      ST_LOCK_A: begin
        w_rr_last_nxt = 1'b0;
        if (a_req_i) begin
          w_gnt_a        = rst_n_i;
          w_lock_cnt_nxt = w_cnt_inc;
          if (!a_lock_i || (w_cnt_inc >= CNT_W'(MAX_LOCK))) begin
            w_state_nxt    = ST_IDLE;
            w_lock_cnt_nxt = '0;
          end
        end else begin
          w_state_nxt    = ST_IDLE;
          w_lock_cnt_nxt = '0;
        end
      end
      ST_LOCK_B: begin
        w_rr_last_nxt = 1'b1;
        if (b_req_i) begin
          w_gnt_b        = rst_n_i;
          w_lock_cnt_nxt = w_cnt_inc;
          if (!b_lock_i || (w_cnt_inc >= CNT_W'(MAX_LOCK))) begin
            w_state_nxt    = ST_IDLE;
            w_lock_cnt_nxt = '0;
          end
        end else begin
          w_state_nxt    = ST_IDLE;
          w_lock_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  // Winner mux toward the memory; idle bus drives zeros
  always_comb begin
    w_gnt_any = w_gnt_a | w_gnt_b;
    w_we      = 1'b0;
    w_addr    = '0;
    w_wdata   = '0;
    if (w_gnt_a) begin
      w_we    = a_we_i;
      w_addr  = a_addr_i;
      w_wdata = a_wdata_i;
    end else if (w_gnt_b) begin
      w_we    = b_we_i;
      w_addr  = b_addr_i;
      w_wdata = b_wdata_i;
    end
  end

`ifdef DMEM_ARB_BOUNDS_CHK_EN
  assign w_oob = w_gnt_any && (w_addr >= ADDR_W'(DEPTH));
`else
  assign w_oob = 1'b0;
`endif

  assign a_gnt_o     = w_gnt_a;
  assign b_gnt_o     = w_gnt_b;
  assign MemWrite_o  = w_gnt_any & w_we & ~w_oob;
  assign MemRead_o   = w_gnt_any & ~w_we & ~w_oob;
  assign addr_o      = w_addr;
  assign WriteData_o = w_wdata;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_rr_last  <= 1'b1;
      r_lock_cnt <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rd_oob   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_last  <= w_rr_last_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_rvalid_a <= w_gnt_a & ~a_we_i;
      r_rvalid_b <= w_gnt_b & ~b_we_i;
      r_rd_oob   <= w_oob & ~w_we;
    end
  end

  // Memory read data is registered, so the owner tag travels one cycle behind the grant
  assign a_rvalid_o = r_rvalid_a;
  assign b_rvalid_o = r_rvalid_b;
  assign a_rdata_o  = (r_rvalid_a && !r_rd_oob) ? ReadData_i : '0;
  assign b_rdata_o  = (r_rvalid_b && !r_rd_oob) ? ReadData_i : '0;

`ifdef DMEM_ARB_BOUNDS_CHK_EN
  logic r_err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err <= 1'b0;
    end else if (w_oob) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_BOUNDS_CHK_EN
  logic              err;
`endif

  logic              pre_we;
  logic [7:0]        pre_addr;
  logic [DATA_W-1:0] pre_data;
  logic [DATA_W-1:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(4), .DEPTH(256)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_lock_i(a_lock), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_lock_i(b_lock), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .MemWrite_o(mem_we), .MemRead_o(mem_re), .addr_o(mem_addr),
    .WriteData_o(mem_wdata), .ReadData_i(mem_rdata)
`ifdef DMEM_ARB_BOUNDS_CHK_EN
    , .err_o(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model with one-cycle registered read
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic preload(input logic [7:0] addr, input logic [DATA_W-1:0] data);
    @(negedge clk);
    pre_we = 1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_we = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    check("rst_memrd", 32'(mem_re), 32'd0);
    rst_n = 1;
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    pre_we = 0; pre_addr = '0; pre_data = '0;
    rst_n = 0;
    preload(8'd5, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      preload(8'(16 + k), 32'hA000_0000 + 32'(k));
      preload(8'(32 + k), 32'hB000_0000 + 32'(k));
    end
    do_reset();

    // Single read from A
    cycle(); a_req = 1; a_addr = 5; #1;
    check("t1_a_gnt", 32'(a_gnt), 32'd1);
    check("t1_b_gnt", 32'(b_gnt), 32'd0);
    check("t1_memrd", 32'(mem_re), 32'd1);
    check("t1_memwr", 32'(mem_we), 32'd0);
    check("t1_addr", mem_addr, 32'd5);
    cycle(); idle_inputs(); #1;
    check("t1_a_rvalid", 32'(a_rvalid), 32'd1);
    check("t1_a_rdata", a_rdata, 32'hDEADBEEF);
    check("t1_b_rvalid", 32'(b_rvalid), 32'd0);
    check("t1_idle_addr", mem_addr, 32'd0);
    cycle(); #1;
    check("t1_a_rvalid_drop", 32'(a_rvalid), 32'd0);

    // Round-robin with both requesting reads every cycle
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (i < 6) begin
        a_req = 1; a_addr = 32'(16 + (i + 1) / 2);
        b_req = 1; b_addr = 32'(32 + i / 2);
      end else begin
        idle_inputs();
      end
      #1;
      if (i < 6) begin
        check("t2_a_gnt", 32'(a_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
        check("t2_b_gnt", 32'(b_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
        check("t2_addr", mem_addr, (i % 2 == 0) ? 32'(16 + i / 2) : 32'(32 + i / 2));
      end
      if (i > 0) begin
        check("t2_a_rvalid", 32'(a_rvalid), ((i - 1) % 2 == 0) ? 32'd1 : 32'd0);
        check("t2_b_rvalid", 32'(b_rvalid), ((i - 1) % 2 == 1) ? 32'd1 : 32'd0);
        if ((i - 1) % 2 == 0) check("t2_a_rdata", a_rdata, 32'hA000_0000 + 32'((i - 1) / 2));
        else                  check("t2_b_rdata", b_rdata, 32'hB000_0000 + 32'((i - 1) / 2));
      end
    end

    // B write then A read of the same word
    do_reset();
    cycle(); b_req = 1; b_we = 1; b_addr = 10; b_wdata = 32'h1234; #1;
    check("t3_b_gnt", 32'(b_gnt), 32'd1);
    check("t3_memwr", 32'(mem_we), 32'd1);
    check("t3_memrd", 32'(mem_re), 32'd0);
    check("t3_wdata", mem_wdata, 32'h1234);
    cycle(); idle_inputs(); a_req = 1; a_addr = 10; #1;
    check("t3_a_gnt", 32'(a_gnt), 32'd1);
    check("t3_memwr_once", 32'(mem_we), 32'd0);
    check("t3_b_rvalid", 32'(b_rvalid), 32'd0);
    cycle(); idle_inputs(); #1;
    check("t3_a_rvalid", 32'(a_rvalid), 32'd1);
    check("t3_a_rdata", a_rdata, 32'h1234);

    // Locked burst of A capped at four grants
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(); a_req = 1; a_lock = 1; a_addr = 1; b_req = 1; b_addr = 2; #1;
      check("t4_a_gnt", 32'(a_gnt), (i == 4) ? 32'd0 : 32'd1);
      check("t4_b_gnt", 32'(b_gnt), (i == 4) ? 32'd1 : 32'd0);
    end
    // A now locked again; dropping req while B requests gives a one-cycle gap
    cycle(); a_req = 0; a_lock = 0; #1;
    check("t4_gap_b_gnt", 32'(b_gnt), 32'd0);
    check("t4_gap_a_gnt", 32'(a_gnt), 32'd0);
    cycle(); #1;
    check("t4_after_b_gnt", 32'(b_gnt), 32'd1);

    // Reset mid-cycle after a locked read grant drops the response
    do_reset();
    cycle(); a_req = 1; a_lock = 1; a_addr = 5; #1;
    check("t5_a_gnt", 32'(a_gnt), 32'd1);
    #2 rst_n = 0;
    #1;
    check("t5_gnt_in_rst", 32'(a_gnt), 32'd0);
    check("t5_memrd_in_rst", 32'(mem_re), 32'd0);
    cycle(); #1;
    check("t5_a_rvalid", 32'(a_rvalid), 32'd0);
    idle_inputs();
    rst_n = 1;
    cycle(); a_req = 1; a_addr = 16; b_req = 1; b_addr = 32; #1;
    check("t5_tie_a_gnt", 32'(a_gnt), 32'd1);
    check("t5_tie_b_gnt", 32'(b_gnt), 32'd0);
    check("t5_a_rvalid_post", 32'(a_rvalid), 32'd0);
    cycle(); idle_inputs(); #1;
    check("t5_a_rdata", a_rdata, 32'hA000_0000);

    // Address beyond DEPTH
    do_reset();
    cycle(); b_req = 1; b_addr = 300; #1;
    check("t6_b_gnt", 32'(b_gnt), 32'd1);
    check("t6_addr", mem_addr, 32'd300);
`ifdef DMEM_ARB_BOUNDS_CHK_EN
    check("t6_memrd_blocked", 32'(mem_re), 32'd0);
    cycle(); idle_inputs(); #1;
    check("t6_b_rvalid", 32'(b_rvalid), 32'd1);
    check("t6_b_rdata", b_rdata, 32'd0);
    check("t6_err", 32'(err), 32'd1);
    cycle(); #1;
    check("t6_err_sticky", 32'(err), 32'd1);
`else
    check("t6_memrd", 32'(mem_re), 32'd1);
    cycle(); idle_inputs(); #1;
    check("t6_b_rvalid", 32'(b_rvalid), 32'd1);
    check("t6_b_rdata", b_rdata, mem[8'd44]);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
